// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS subset CPU with internal IMEM, register file and DMEM.

// Instruction memory: combinational read; the write port is a program-load hook held idle by the CPU.
module imem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [7:0]  addr,
    output logic [31:0] rdata
);
    logic [31:0] memory [0:255];

    // Program load write
    always_ff @(posedge clk) begin
        if (we) begin
            memory[waddr] <= wdata;
        end
    end

    assign rdata = memory[addr];
endmodule

// Register file: two combinational read ports, one write port, $0 hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] registers [0:31];

    // Reset clears every register; writes to $0 are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= 32'd0;
            end
        end else if (we && (wa != 5'd0)) begin
            registers[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

// Data memory: combinational read, write on the rising edge.
module dmem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] memory [0:255];

    // Word store
    always_ff @(posedge clk) begin
        if (we) begin
            memory[addr] <= wdata;
        end
    end

    assign rdata = memory[addr];
endmodule

module mips_cpu (
    input  logic clk,
    input  logic reset
);
    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] sext_imm;
    logic [XLEN-1:0] zext_imm;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wr_data;
    logic [4:0]      wr_addr;
    logic            reg_write;
    logic            mem_write;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign target = instr[25:0];

    assign pc_plus4 = pc + 32'd4;
    assign sext_imm = {{16{imm[15]}}, imm};
    assign zext_imm = {16'd0, imm};
    assign mem_addr = rs_val + sext_imm;

    imem im (
        .clk   (clk),
        .we    (1'b0),
        .waddr (8'd0),
        .wdata (32'd0),
        .addr  (pc[9:2]),
        .rdata (instr)
    );

    regfile rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (reg_write),
        .wa    (wr_addr),
        .wd    (wr_data)
    );

    // Reset blocks the store of an aborted instruction
    dmem dm (
        .clk   (clk),
        .we    (mem_write & ~reset),
        .addr  (mem_addr[9:2]),
        .wdata (rt_val),
        .rdata (load_data)
    );

    // Decode and execute; unsupported encodings fall through as NOP
    always_comb begin
        reg_write = 1'b0;
        wr_addr   = rt;
        wr_data   = 32'd0;
        mem_write = 1'b0;
        next_pc   = pc_plus4;
        unique case (op)
            OP_RTYPE: begin
                wr_addr = rd;
                unique case (funct)
                    FN_ADD, FN_ADDU: begin reg_write = 1'b1; wr_data = rs_val + rt_val;    end
                    FN_SUB, FN_SUBU: begin reg_write = 1'b1; wr_data = rs_val - rt_val;    end
                    FN_AND:          begin reg_write = 1'b1; wr_data = rs_val & rt_val;    end
                    FN_OR:           begin reg_write = 1'b1; wr_data = rs_val | rt_val;    end
                    FN_NOR:          begin reg_write = 1'b1; wr_data = ~(rs_val | rt_val); end
                    FN_SLT: begin
                        reg_write = 1'b1;
                        wr_data   = 32'($signed(rs_val) < $signed(rt_val));
                    end
                    default: ;
                endcase
            end
            OP_LW:             begin reg_write = 1'b1; wr_data = load_data;         end
            OP_SW:             begin mem_write = 1'b1;                              end
            OP_ADDI, OP_ADDIU: begin reg_write = 1'b1; wr_data = rs_val + sext_imm; end
            OP_ANDI:           begin reg_write = 1'b1; wr_data = rs_val & zext_imm; end
            OP_ORI:            begin reg_write = 1'b1; wr_data = rs_val | zext_imm; end
            OP_BEQ: begin
                if (rs_val == rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
            end
            OP_BNE: begin
                if (rs_val != rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
            end
            OP_J:    next_pc = {pc_plus4[31:28], target, 2'b00};
            default: ;
        endcase
    end

    // Program counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= 32'd0;
        end else begin
            pc <= next_pc;
        end
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: directed cases plus a random program against an ISA-level model.
module tb_mips_cpu;
    logic clk;
    logic reset;

    int unsigned n_asserts;
    int unsigned n_fails;

    // Architectural reference model state
    logic [31:0] prog  [0:255];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_dm  [0:255];
    logic [31:0] m_pc;

    mips_cpu dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            dut.im.memory[i] = 32'd0;
            dut.dm.memory[i] = 32'd0;
        end
    endtask

    // One instruction executed from the ISA description
    function automatic void model_step();
        logic [31:0] ins, a, b, sx, zx, pc4, res, addr;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        logic        wr;
        ins = prog[m_pc[9:2]];
        op  = ins[31:26];
        fn  = ins[5:0];
        a   = m_reg[ins[25:21]];
        b   = m_reg[ins[20:16]];
        sx  = {{16{ins[15]}}, ins[15:0]};
        zx  = {16'd0, ins[15:0]};
        pc4 = m_pc + 32'd4;
        addr = a + sx;
        wr  = 1'b0;
        dst = ins[20:16];
        res = 32'd0;
        m_pc = pc4;
        case (op)
            6'h00: begin
                dst = ins[15:11];
                wr  = 1'b1;
                case (fn)
                    6'h20, 6'h21: res = a + b;
                    6'h22, 6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            6'h23: begin wr = 1'b1; res = m_dm[addr[9:2]]; end
            6'h2B: m_dm[addr[9:2]] = b;
            6'h08, 6'h09: begin wr = 1'b1; res = a + sx; end
            6'h0C: begin wr = 1'b1; res = a & zx; end
            6'h0D: begin wr = 1'b1; res = a | zx; end
            6'h04: if (a == b) m_pc = pc4 + (sx << 2);
            6'h05: if (a != b) m_pc = pc4 + (sx << 2);
            6'h02: m_pc = {pc4[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (wr && dst != 5'd0) m_reg[dst] = res;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fns [0:8];
        int unsigned k;
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
        rs  = 5'($urandom_range(0, 31));
        rt  = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        k   = $urandom_range(0, 11);
        case (k)
            0, 1, 2: return {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 8)]};
            3:  return {6'h23, rs, rt, imm};
            4:  return {6'h2B, rs, rt, imm};
            5:  return {6'h08, rs, rt, imm};
            6:  return {6'h09, rs, rt, imm};
            7:  return {6'h0C, rs, rt, imm};
            8:  return {6'h0D, rs, rt, imm};
            9:  return {6'h04, rs, rt, 16'($urandom_range(0, 7))};
            10: return {6'h05, rs, rt, 16'($urandom_range(0, 7))};
            default: return {6'h02, 26'($urandom_range(0, 255))};
        endcase
    endfunction

    initial begin
        n_asserts = 0;
        n_fails   = 0;
        reset     = 1'b1;
        clear_mem();

        // Reset clears registers and PC
        dut.rf.registers[7] = 32'd123;
        do_reset();
        chk("reset_pc", dut.pc, 32'd0);
        chk("reset_r7", dut.rf.registers[7], 32'd0);

        // add / sw / lw chain
        dut.im.memory[0] = 32'h00430820;
        dut.im.memory[1] = 32'hAC010000;
        dut.im.memory[2] = 32'h8C040000;
        dut.rf.registers[2] = 32'd5;
        dut.rf.registers[3] = 32'd6;
        tick();
        chk("add_r1", dut.rf.registers[1], 32'd11);
        tick();
        chk("sw_dm0", dut.dm.memory[0], 32'd11);
        tick();
        chk("lw_r4", dut.rf.registers[4], 32'd11);
        chk("lw_pc", dut.pc, 32'd12);

        // Writes to $0 are discarded
        clear_mem();
        do_reset();
        dut.im.memory[0] = 32'h20000007;
        dut.im.memory[1] = 32'h00002820;
        dut.rf.registers[5] = 32'd9;
        tick();
        chk("r0_zero", dut.rf.registers[0], 32'd0);
        tick();
        chk("add_r5_zero", dut.rf.registers[5], 32'd0);

        // beq taken skips two instructions
        do_reset();
        dut.im.memory[0] = 32'h10220002;
        dut.im.memory[1] = 32'h20090001;
        dut.im.memory[2] = 32'h20090001;
        dut.rf.registers[1] = 32'd3;
        dut.rf.registers[2] = 32'd3;
        tick();
        chk("beq_taken_pc", dut.pc, 32'd12);
        chk("beq_skip_r9", dut.rf.registers[9], 32'd0);
        do_reset();
        dut.rf.registers[1] = 32'd3;
        dut.rf.registers[2] = 32'd4;
        tick();
        chk("beq_not_taken_pc", dut.pc, 32'd4);

        // Arithmetic edges
        do_reset();
        dut.im.memory[0] = 32'h00430822;
        dut.rf.registers[2] = 32'd0;
        dut.rf.registers[3] = 32'd1;
        tick();
        chk("sub_wrap", dut.rf.registers[1], 32'hFFFFFFFF);
        do_reset();
        dut.im.memory[0] = 32'h0043082A;
        dut.rf.registers[2] = 32'hFFFFFFFF;
        dut.rf.registers[3] = 32'd1;
        tick();
        chk("slt_signed", dut.rf.registers[1], 32'd1);
        do_reset();
        dut.im.memory[0] = 32'h2041FFFF;
        dut.rf.registers[2] = 32'd10;
        tick();
        chk("addi_neg", dut.rf.registers[1], 32'd9);

        // Jump, then reset during a store
        clear_mem();
        do_reset();
        dut.im.memory[0]  = 32'h08000010;
        dut.im.memory[16] = 32'hAC010000;
        dut.dm.memory[0]  = 32'h77;
        tick();
        chk("j_pc", dut.pc, 32'h40);
        dut.rf.registers[1] = 32'h55;
        do_reset();
        chk("rst_sw_dm0", dut.dm.memory[0], 32'h77);
        chk("rst_sw_pc", dut.pc, 32'd0);
        for (int i = 0; i < 32; i++) chk($sformatf("rst_reg%0d", i), dut.rf.registers[i], 32'd0);

        // Unknown opcode behaves as NOP
        do_reset();
        dut.im.memory[0] = 32'hFC221234;
        dut.rf.registers[1] = 32'h11;
        dut.rf.registers[2] = 32'h22;
        dut.dm.memory[5] = 32'hAB;
        tick();
        chk("nop_pc", dut.pc, 32'd4);
        chk("nop_r1", dut.rf.registers[1], 32'h11);
        chk("nop_r2", dut.rf.registers[2], 32'h22);
        chk("nop_dm0", dut.dm.memory[0], 32'h77);
        chk("nop_dm5", dut.dm.memory[5], 32'hAB);

        // Random program against the reference model
        do_reset();
        for (int i = 0; i < 256; i++) begin
            prog[i] = rand_instr();
            dut.im.memory[i] = prog[i];
            m_dm[i] = $urandom;
            dut.dm.memory[i] = m_dm[i];
        end
        m_reg[0] = 32'd0;
        for (int i = 1; i < 32; i++) begin
            m_reg[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
            dut.rf.registers[i] = m_reg[i];
        end
        m_pc = 32'd0;
        for (int s = 0; s < 200; s++) begin
            tick();
            model_step();
            chk($sformatf("rand_pc_s%0d", s), dut.pc, m_pc);
            for (int i = 0; i < 32; i++)
                chk($sformatf("rand_r%0d_s%0d", i, s), dut.rf.registers[i], m_reg[i]);
        end
        for (int i = 0; i < 256; i++) chk($sformatf("rand_dm%0d", i), dut.dm.memory[i], m_dm[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
